// File: rtl/addsub_issue_collector.sv
// Issue/collect wrapper around a fixed-latency add/sub pipeline: registers requests into the
// pipeline, reserves FIFO credit per request and buffers returning results for downstream.
module addsub_issue_collector #(
    parameter int unsigned DATAWIDTH    = 8,
    parameter int unsigned PIPE_LATENCY = 4,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATAWIDTH-1:0] s_a,
    input  logic [DATAWIDTH-1:0] s_b,
    input  logic                 s_op,

    output logic [DATAWIDTH-1:0] p_A,
    output logic [DATAWIDTH-1:0] p_B,
    output logic                 p_op,
    output logic                 p_i_valid,
    input  logic [DATAWIDTH-1:0] p_Result,
    input  logic                 p_carry_borrow,
    input  logic                 p_o_valid,

    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATAWIDTH-1:0] m_result,
    output logic                 m_carry,

    output logic                 busy,
    output logic                 err_unexpected
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = DATAWIDTH + 1;

    logic [CW-1:0]        r_used;
    logic [CW-1:0]        w_used_d;
    logic [CW-1:0]        r_inflight;
    logic [CW-1:0]        w_inflight_d;
    logic [CW-1:0]        r_wptr;
    logic [CW-1:0]        r_rptr;
    logic [EW-1:0]        r_mem [FIFO_DEPTH];
    logic                 r_s_ready;
    logic                 r_err;
    logic                 r_p_valid;
    logic [DATAWIDTH-1:0] r_p_a;
    logic [DATAWIDTH-1:0] r_p_b;
    logic                 r_p_op;

    logic                 w_accept;
    logic                 w_pop;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_expected;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_unexp;
    logic [EW-1:0]        w_head;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);

    assign w_accept = s_valid && r_s_ready;
    assign w_pop    = !w_empty && m_ready;

    // With zero latency the result returns in the same cycle it is issued.
    assign w_expected = p_o_valid &&
                        ((r_inflight != '0) || ((PIPE_LATENCY == 0) && r_p_valid));
    assign w_push     = w_expected && !w_full;
    assign w_drop     = w_expected && w_full;
    assign w_unexp    = p_o_valid && !w_expected;

    always_comb begin
        w_used_d = r_used;
        case ({w_accept, w_pop})
            2'b10:   w_used_d = r_used + CW'(1);
            2'b01:   w_used_d = r_used - CW'(1);
            default: w_used_d = r_used;
        endcase
    end

    always_comb begin
        w_inflight_d = r_inflight;
        case ({r_p_valid, w_expected})
            2'b10:   w_inflight_d = r_inflight + CW'(1);
            2'b01:   w_inflight_d = r_inflight - CW'(1);
            default: w_inflight_d = r_inflight;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_used     <= '0;
            r_inflight <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_s_ready  <= 1'b0;
            r_err      <= 1'b0;
            r_p_valid  <= 1'b0;
            r_p_a      <= '0;
            r_p_b      <= '0;
            r_p_op     <= 1'b0;
        end else begin
            r_used     <= w_used_d;
            r_inflight <= w_inflight_d;
            // Registered so s_ready has no combinational path from m_ready or s_valid.
            r_s_ready  <= (w_used_d < CW'(FIFO_DEPTH));
            r_p_valid  <= w_accept;
            if (w_accept) begin
                r_p_a  <= s_a;
                r_p_b  <= s_b;
                r_p_op <= s_op;
            end
            if (w_push) begin
                r_wptr <= r_wptr + CW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + CW'(1);
            end
            if (w_unexp || w_drop) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[PW-1:0]] <= {p_Result, p_carry_borrow};
        end
    end

    assign w_head = r_mem[r_rptr[PW-1:0]];

    assign s_ready        = r_s_ready;
    assign p_A            = r_p_a;
    assign p_B            = r_p_b;
    assign p_op           = r_p_op;
    assign p_i_valid      = r_p_valid;
    assign m_valid        = !w_empty;
    assign m_result       = w_empty ? '0 : w_head[EW-1:1];
    assign m_carry        = !w_empty && w_head[0];
    assign busy           = (r_used != '0);
    assign err_unexpected = r_err;

endmodule

// File: tb/tb_addsub_issue_collector.sv
// Directed bench for addsub_issue_collector with a behavioural 4-stage add/sub pipeline attached.
module tb_addsub_issue_collector;

    localparam int DW = 8;
    localparam int PL = 4;
    localparam int FD = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_ready, s_op;
    logic [DW-1:0] s_a, s_b;
    logic [DW-1:0] p_A, p_B, p_Result;
    logic          p_op, p_i_valid, p_carry_borrow, p_o_valid;
    logic          m_valid, m_ready, m_carry;
    logic [DW-1:0] m_result;
    logic          busy, err_unexpected;
    logic          inj;

    logic [PL-1:0] pv;
    logic [DW:0]   pr [PL];

    typedef struct {
        logic [DW:0] v;
        int          cyc;
    } ent_t;

    ent_t exp_q[$];
    ent_t got_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    addsub_issue_collector #(
        .DATAWIDTH   (DW),
        .PIPE_LATENCY(PL),
        .FIFO_DEPTH  (FD)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_a           (s_a),
        .s_b           (s_b),
        .s_op          (s_op),
        .p_A           (p_A),
        .p_B           (p_B),
        .p_op          (p_op),
        .p_i_valid     (p_i_valid),
        .p_Result      (p_Result),
        .p_carry_borrow(p_carry_borrow),
        .p_o_valid     (p_o_valid),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_result      (m_result),
        .m_carry       (m_carry),
        .busy          (busy),
        .err_unexpected(err_unexpected)
    );

    // Returns {carry/no-borrow, result}.
    function automatic logic [DW:0] golden(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic op);
        if (op) return {1'b0, a} + {1'b0, ~b} + 9'd1;
        return {1'b0, a} + {1'b0, b};
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            pv <= '0;
            for (int i = 0; i < PL; i++) pr[i] <= '0;
        end else begin
            pv    <= {pv[PL-2:0], p_i_valid};
            pr[0] <= golden(p_A, p_B, p_op);
            for (int i = 1; i < PL; i++) pr[i] <= pr[i-1];
        end
    end

    assign p_o_valid      = pv[PL-1] | inj;
    assign p_Result       = pr[PL-1][DW-1:0];
    assign p_carry_borrow = pr[PL-1][DW];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (s_valid && s_ready) exp_q.push_back('{v: golden(s_a, s_b, s_op), cyc: cyc});
            if (m_valid && m_ready) got_q.push_back('{v: {m_carry, m_result}, cyc: cyc});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int b;
        b = 0;
        while (got_q.size() < exp_q.size() && b < budget) begin
            tick();
            b++;
        end
        tick(2);
        check_eq(tag, got_q.size(), exp_q.size());
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
    endtask

    int k;
    int stalls;
    logic was_ready;

    initial begin
        rst = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; s_op = 1'b0;
        m_ready = 1'b0; inj = 1'b0;
        tick(3);
        check_eq("rst_s_ready", s_ready, 0);
        check_eq("rst_p_i_valid", p_i_valid, 0);
        check_eq("rst_p_A", p_A, 0);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_result", m_result, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err", err_unexpected, 0);
        rst = 1'b1;
        tick();
        check_eq("ready_after_release", s_ready, 1);

        // Single add: accept at cycle 0
        clear_q();
        m_ready = 1'b1;
        s_a = 8'd200; s_b = 8'd100; s_op = 1'b0; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check_eq("add_p_i_valid_c1", p_i_valid, 1);
        check_eq("add_p_A", p_A, 200);
        check_eq("add_p_B", p_B, 100);
        tick(4);
        check_eq("add_m_valid_c5", m_valid, 0);
        tick();
        check_eq("add_m_valid_c6", m_valid, 1);
        check_eq("add_m_result", m_result, 44);
        check_eq("add_m_carry", m_carry, 1);
        tick();
        check_eq("add_busy_c7", busy, 0);
        check_eq("add_m_valid_c7", m_valid, 0);

        // Subtracts in order
        clear_q();
        s_valid = 1'b1; s_a = 8'd5; s_b = 8'd7; s_op = 1'b1;
        tick();
        s_a = 8'd7; s_b = 8'd5;
        tick();
        s_valid = 1'b0;
        wait_drain("sub_count", 20);
        if (got_q.size() >= 2) begin
            check_eq("sub_5m7", got_q[0].v, 9'h0FE);
            check_eq("sub_7m5", got_q[1].v, 9'h102);
        end

        // Backpressure fill
        clear_q();
        m_ready = 1'b0; k = 0; s_b = 8'd0; s_op = 1'b0; s_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            s_a = k[DW-1:0];
            was_ready = s_ready;
            tick();
            if (was_ready) k++;
        end
        check_eq("bp_accepts", k, FD);
        check_eq("bp_s_ready_low", s_ready, 0);
        check_eq("bp_busy", busy, 1);
        m_ready = 1'b1;
        tick();
        check_eq("bp_ready_after_pop", s_ready, 1);
        s_valid = 1'b0;
        wait_drain("bp_count", 30);
        for (int i = 0; i < got_q.size(); i++) begin
            check_eq("bp_value", got_q[i].v, i);
            check_eq("bp_spacing", got_q[i].cyc - got_q[0].cyc, i);
        end

        // Streaming random
        clear_q();
        stalls = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_a = DW'($urandom); s_b = DW'($urandom); s_op = 1'($urandom);
            s_valid = 1'b1;
            if (!s_ready) stalls++;
            tick();
        end
        s_valid = 1'b0;
        check_eq("stream_stalls", stalls, 0);
        wait_drain("stream_count", 50);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check_eq("stream_value", got_q[i].v, exp_q[i].v);
            check_eq("stream_lag", got_q[i].cyc - exp_q[i].cyc, 6);
        end

        // Spurious pipeline output
        clear_q();
        tick(3);
        check_eq("spur_err_before", err_unexpected, 0);
        inj = 1'b1;
        tick();
        inj = 1'b0;
        check_eq("spur_err", err_unexpected, 1);
        check_eq("spur_m_valid", m_valid, 0);
        tick(3);
        check_eq("spur_err_held", err_unexpected, 1);
        check_eq("spur_m_valid_held", m_valid, 0);
        check_eq("spur_busy", busy, 0);

        // Reset with 3 ops in pipeline and 2 in FIFO
        clear_q();
        m_ready = 1'b0; s_valid = 1'b1; s_op = 1'b0; s_b = 8'd1;
        for (int i = 0; i < 5; i++) begin
            s_a = DW'(i + 10);
            tick();
        end
        s_valid = 1'b0;
        tick(2);
        check_eq("mid_m_valid_pre", m_valid, 1);
        check_eq("mid_busy_pre", busy, 1);
        rst = 1'b0;
        tick();
        check_eq("mid_s_ready", s_ready, 0);
        check_eq("mid_p_i_valid", p_i_valid, 0);
        check_eq("mid_p_A", p_A, 0);
        check_eq("mid_m_valid", m_valid, 0);
        check_eq("mid_m_result", m_result, 0);
        check_eq("mid_m_carry", m_carry, 0);
        check_eq("mid_busy", busy, 0);
        check_eq("mid_err", err_unexpected, 0);
        clear_q();
        rst = 1'b1;
        tick();
        check_eq("mid_ready_release", s_ready, 1);
        m_ready = 1'b1;
        s_a = 8'd9; s_b = 8'd3; s_op = 1'b0; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        wait_drain("post_count", 20);
        if (got_q.size() >= 1 && exp_q.size() >= 1) begin
            check_eq("post_value", got_q[0].v, 9'd12);
            check_eq("post_lag", got_q[0].cyc - exp_q[0].cyc, 6);
        end
        check_eq("post_err", err_unexpected, 0);
        check_eq("post_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/addsub_issue_collector.md
# addsub_issue_collector

Issue/collect wrapper placed around an `AdderSubtractorPipelined` instance. It accepts operand requests from upstream over a valid/ready handshake and drives them into the pipeline, which has no backpressure. Results returning from the pipeline are captured into an internal result FIFO and presented downstream over valid/ready. Credit accounting guarantees that every issued operation has FIFO space reserved before it enters the pipeline, so no result is ever dropped.

## Interface
- `DATAWIDTH`, 8, operand/result width; must match the attached pipeline.
- `PIPE_LATENCY`, 4, cycles from `p_i_valid` to `p_o_valid` of the attached pipeline (its number of enabled stages); 0 is legal.
- `FIFO_DEPTH`, 8, result FIFO entries; must be a power of two and ≥ `PIPE_LATENCY`+2.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `s_valid`  in  1  upstream request valid.
- `s_ready`  out  1  upstream request accepted when high with `s_valid`.
- `s_a`, `s_b`  in  DATAWIDTH each  operands.
- `s_op`  in  1  0 = add, 1 = subtract.
- `p_A`, `p_B`  out  DATAWIDTH each  to pipeline `A`/`B`.
- `p_op`  out  1  to pipeline `op`.
- `p_i_valid`  out  1  to pipeline `i_valid`.
- `p_Result`  in  DATAWIDTH  from pipeline `Result`.
- `p_carry_borrow`  in  1  from pipeline `carry_borrow`.
- `p_o_valid`  in  1  from pipeline `o_valid`.
- `m_valid`  out  1  downstream result valid.
- `m_ready`  in  1  downstream accept.
- `m_result`  out  DATAWIDTH  result.
- `m_carry`  out  1  carry (add) / no-borrow (subtract), passed through unchanged.
- `busy`  out  1  high while any operation is outstanding (issued, in pipeline, or in the FIFO).
- `err_unexpected`  out  1  sticky; a `p_o_valid` arrived with zero operations in flight.

## Operation
- **Issue register:** on an `s_valid && s_ready` edge, `p_A`/`p_B`/`p_op` load `s_a`/`s_b`/`s_op` and `p_i_valid`=1 for the next cycle. Otherwise `p_i_valid`=0 and the data outputs hold their last value.
- **Credit counter `used`** (0..`FIFO_DEPTH`):
  - +1 on each upstream accept, −1 on each downstream handshake (`m_valid && m_ready`).
  - Both in the same cycle: unchanged.
  - `s_ready` = (`used` < `FIFO_DEPTH`). It is driven from the registered `used` only, with no combinational path from `m_ready` or `s_valid`.
- **In-flight counter `inflight`:**
  - +1 when `p_i_valid`=1, −1 when `p_o_valid`=1; both together: unchanged.
  - `p_o_valid` while `inflight`=0: set `err_unexpected`, discard the beat (no FIFO write), leave `inflight` at 0.
- **Result FIFO:**
  - Writes {`p_Result`, `p_carry_borrow`} on an expected `p_o_valid`.
  - Read and write pointers are log2(`FIFO_DEPTH`)+1 bits and wrap naturally.
  - Full: write ptr == read ptr with MSBs differing. Empty: pointers equal.
  - A write while full cannot occur under credit rules. If it does anyway, the beat is dropped and `err_unexpected` is set.
  - Simultaneous read and write while full or empty are both legal. The written entry is readable the following cycle (no bypass).
- **Downstream:**
  - `m_valid` = FIFO not empty. `m_result`/`m_carry` come from the FIFO head.
  - Stable while `m_valid && !m_ready`. Pops on handshake.
- **Ordering:** results leave in request order; the pipeline is in-order and the FIFO is FIFO.
- `busy` = (`used` ≠ 0).
- Arithmetic is performed only by the pipeline; this block never modifies data.

## Timing
- **Reset** (`rst`=0 at a clock edge):
  - `s_ready`=0 during reset; 1 on the first cycle after release.
  - `p_i_valid`=0, `p_A`=`p_B`=0, `p_op`=0.
  - `m_valid`=0, `m_result`=0, `m_carry`=0.
  - `busy`=0, `err_unexpected`=0.
  - `used`, `inflight` and the pointers are cleared.
- **Reset mid-operation:** all state clears and any in-flight results are lost. The integrator resets the pipeline on the same `rst`. A late `p_o_valid` after release sets `err_unexpected`.
- **Latency:** upstream accept at cycle t gives `p_i_valid` at t+1, `p_o_valid` at t+1+`PIPE_LATENCY`, and `m_valid` at t+2+`PIPE_LATENCY`.
- **Throughput:** one operation per cycle sustained when `m_ready`=1. This holds because `FIFO_DEPTH` ≥ `PIPE_LATENCY`+2 covers the round trip.
- **Full stall:** with `used`=`FIFO_DEPTH`, a downstream pop at cycle t raises `s_ready` at t+1.

## Test plan
- **Add:** `PIPE_LATENCY`=4, `m_ready`=1; one request `s_a`=200, `s_b`=100, `s_op`=0 accepted at cycle 0.
  - Required: `p_i_valid` at cycle 1.
  - Required: `m_valid` at cycle 6 with `m_result`=44, `m_carry`=1.
  - Required: `busy` drops at cycle 7.
- **Subtract:** 5−7, then 7−5.
  - Required: 8'hFE, `m_carry`=0, then 8'h02, `m_carry`=1, in order.
- **Backpressure:** `m_ready`=0; drive `s_valid`=1 continuously with operands 0..15.
  - Required: exactly 8 accepts, then `s_ready`=0.
  - Release `m_ready`: results 0+k appear in order, one per cycle, with no loss or duplication. `s_ready` returns 1 the cycle after the first pop.
- **Streaming:** 100 random back-to-back requests with `m_ready`=1.
  - Required: `s_ready` never deasserts; outputs match the golden model with a constant 6-cycle lag.
- **Spurious result:** inject `p_o_valid`=1 with `inflight`=0.
  - Required: `err_unexpected`=1 the next cycle and held; FIFO stays empty; `m_valid` stays 0.
- **Reset mid-flight:** assert `rst`=0 for 1 cycle with 3 operations in the pipeline and 2 in the FIFO.
  - Required: all outputs at reset values next cycle and `m_valid`=0.
  - Required: a new request afterwards completes normally.
